// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned N_PORTS = 3;
    localparam int unsigned CNT_W   = 3;   // holds MEM_LAT up to 4
    localparam int unsigned BURST_W = 4;   // holds VGA_BURST up to 15

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t ACK   = 2'd3;

    typedef logic [1:0] grant_t;
    localparam grant_t PORT_I = 2'd0;
    localparam grant_t PORT_D = 2'd1;
    localparam grant_t PORT_V = 2'd2;

    // Registered memory-side command of the access in flight.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: VGA first unless its burst budget is spent, CPU ports round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] reqs,
    input  grant_t             rr_ptr,
    input  logic               burst_limit,
    output grant_t             gnt_c,
    output logic               gnt_valid_c
);

    logic cpu_any;

    always_comb begin
        cpu_any     = reqs[PORT_I] | reqs[PORT_D];
        gnt_valid_c = |reqs;
        gnt_c       = PORT_I;
        if (reqs[PORT_V] && !(burst_limit && cpu_any)) begin
            gnt_c = PORT_V;
        end else if (rr_ptr == PORT_D) begin
            gnt_c = reqs[PORT_D] ? PORT_D : PORT_I;
        end else begin
            gnt_c = reqs[PORT_I] ? PORT_I : PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter for CPU ifetch, CPU data and VGA fetch; one access in flight,
// every output driven from a register.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned VGA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_ack,
    output logic [DATA_W-1:0] v_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   lat_q, lat_n;
    logic [BURST_W-1:0] burst_q, burst_n;
    grant_t             rr_q, rr_n;
    grant_t             gnt_q, gnt_n;
    mem_cmd_t           cmd_q, cmd_n;
    logic               mem_en_n, i_ack_n, d_ack_n, v_ack_n;
    logic [DATA_W-1:0]  i_rdata_n, d_rdata_n, v_rdata_n;

    grant_t             pick_gnt_c;
    logic               pick_valid_c;
    logic               burst_limit_c;
    logic               cpu_any_c;

    assign cpu_any_c     = i_req | d_req;
    assign burst_limit_c = (burst_q == BURST_W'(VGA_BURST));

    mem_arb_pick u_pick (
        .reqs        ({v_req, d_req, i_req}),
        .rr_ptr      (rr_q),
        .burst_limit (burst_limit_c),
        .gnt_c       (pick_gnt_c),
        .gnt_valid_c (pick_valid_c)
    );

    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        lat_n     = lat_q;
        burst_n   = burst_q;
        rr_n      = rr_q;
        gnt_n     = gnt_q;
        cmd_n     = cmd_q;
        mem_en_n  = 1'b0;
        i_ack_n   = 1'b0;
        d_ack_n   = 1'b0;
        v_ack_n   = 1'b0;
        i_rdata_n = i_rdata;
        d_rdata_n = d_rdata;
        v_rdata_n = v_rdata;

        case (state_q)
            IDLE: begin
                if (!cpu_any_c) begin
                    burst_n = '0;
                end
                if (pick_valid_c) begin
                    state_n  = ISSUE;
                    gnt_n    = pick_gnt_c;
                    mem_en_n = 1'b1;
                    case (pick_gnt_c)
                        PORT_I: begin
                            cmd_n.we   = 1'b0;
                            cmd_n.addr = i_addr;
                        end
                        PORT_D: begin
                            cmd_n.we    = d_we;
                            cmd_n.addr  = d_addr;
                            cmd_n.wdata = d_wdata;
                        end
                        default: begin
                            cmd_n.we   = 1'b0;
                            cmd_n.addr = v_addr;
                        end
                    endcase
                    if (pick_gnt_c == PORT_V) begin
                        if (!cpu_any_c) begin
                            burst_n = '0;
                        end else if (!burst_limit_c) begin
                            burst_n = burst_q + BURST_W'(1);
                        end
                    end else begin
                        burst_n = '0;
                        rr_n    = (pick_gnt_c == PORT_I) ? PORT_D : PORT_I;
                    end
                end
            end
            ISSUE: begin
                lat_n   = CNT_W'(MEM_LAT);
                state_n = WAIT;
            end
            WAIT: begin
                lat_n = lat_q - CNT_W'(1);
                // Last wait cycle is the one where mem_rdata is valid.
                if (lat_q == CNT_W'(1)) begin
                    state_n = ACK;
                    if (!cmd_q.we) begin
                        case (gnt_q)
                            PORT_I:  i_rdata_n = mem_rdata;
                            PORT_D:  d_rdata_n = mem_rdata;
                            default: v_rdata_n = mem_rdata;
                        endcase
                    end
                end
            end
            ACK: begin
                state_n = IDLE;
                case (gnt_q)
                    PORT_I:  i_ack_n = 1'b1;
                    PORT_D:  d_ack_n = 1'b1;
                    default: v_ack_n = 1'b1;
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            burst_q <= '0;
            rr_q    <= PORT_I;
            gnt_q   <= PORT_I;
            cmd_q   <= '0;
            mem_en  <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            v_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            v_rdata <= '0;
        end else begin
            state_q <= state_n;
            lat_q   <= lat_n;
            burst_q <= burst_n;
            rr_q    <= rr_n;
            gnt_q   <= gnt_n;
            cmd_q   <= cmd_n;
            mem_en  <= mem_en_n;
            i_ack   <= i_ack_n;
            d_ack   <= d_ack_n;
            v_ack   <= v_ack_n;
            i_rdata <= i_rdata_n;
            d_rdata <= d_rdata_n;
            v_rdata <= v_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter; two parameter sets run side by side.
module tb_mem_arbiter;

    localparam int RUN = 3000;
    localparam int TMO = 100;

    typedef struct {
        int          cyc;
        logic [1:0]  port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic chk(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [cfg%0d] %s: got %h, expected %h", inst, name, act, exp);
        end
    endtask

    // Power-on content of every memory word not yet written.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int LAT   = (g == 0) ? 1 : 3;
        localparam int BURST = (g == 0) ? 4 : 2;

        logic        rst = 1'b1;
        logic        i_req = 1'b0, d_req = 1'b0, v_req = 1'b0, d_we = 1'b0;
        logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, v_addr = '0;
        logic        i_ack, d_ack, v_ack, mem_en, mem_we;
        logic [31:0] i_rdata, d_rdata, v_rdata, mem_addr, mem_wdata;
        logic [31:0] mem_rdata = '0;

        mem_arbiter #(.MEM_LAT(LAT), .VGA_BURST(BURST)) dut (
            .clk(clk), .rst(rst),
            .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_ack(d_ack), .d_rdata(d_rdata),
            .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        int   cyc = 0;
        bit   last_rst = 1'b1;
        exp_t q_issue[$];
        exp_t q_ack[$];
        exp_t pend[$];
        logic [31:0] ram_m [logic [31:0]];
        logic [31:0] ram_p [logic [31:0]];

        // Reference model: decides each grant from the arbitration rules and the access timing.
        initial begin
            int   next_s = 0;
            bit   rr_d = 1'b0;
            int   bcnt = 0;
            bit   cpu;
            exp_t e;
            forever begin
                @(posedge clk);
                cyc++;
                last_rst = rst;
                cpu = i_req | d_req;
                if (rst) begin
                    rr_d = 1'b0; bcnt = 0; next_s = cyc + 1;
                    q_issue.delete(); q_ack.delete();
                end else if (cyc >= next_s) begin
                    if (!cpu) bcnt = 0;
                    if (cpu || v_req) begin
                        if (v_req && !(bcnt == BURST && cpu)) e.port = 2;
                        else if (i_req && d_req)              e.port = rr_d ? 2'd1 : 2'd0;
                        else                                  e.port = i_req ? 2'd0 : 2'd1;
                        if (e.port == 2) begin
                            if (cpu && bcnt < BURST) bcnt++;
                        end else begin
                            bcnt = 0;
                            rr_d = (e.port == 0);
                        end
                        e.we    = (e.port == 1) ? d_we : 1'b0;
                        e.addr  = (e.port == 0) ? i_addr : (e.port == 1) ? d_addr : v_addr;
                        e.wdata = d_wdata;
                        e.rdata = ram_m.exists(e.addr) ? ram_m[e.addr] : init_word(e.addr);
                        if (e.we) ram_m[e.addr] = e.wdata;
                        e.cyc = cyc;
                        q_issue.push_back(e);
                        e.cyc = cyc + LAT + 2;
                        q_ack.push_back(e);
                        next_s = cyc + LAT + 3;
                    end else begin
                        next_s = cyc + 1;
                    end
                end
            end
        end

        // Memory: data valid exactly LAT cycles after the mem_en cycle, garbage otherwise.
        initial begin
            exp_t p;
            forever begin
                @(negedge clk);
                if (last_rst) pend.delete();
                mem_rdata = $urandom;
                if (pend.size() > 0 && pend[0].cyc == cyc) begin
                    mem_rdata = pend[0].rdata;
                    void'(pend.pop_front());
                end
                if (mem_en && !last_rst) begin
                    if (mem_we) begin
                        ram_p[mem_addr] = mem_wdata;
                    end else begin
                        p.cyc   = cyc + LAT;
                        p.rdata = ram_p.exists(mem_addr) ? ram_p[mem_addr] : init_word(mem_addr);
                        pend.push_back(p);
                    end
                end
            end
        end

        // Monitor: compares every memory strobe and every ack against the scoreboard.
        initial begin
            exp_t        e;
            logic [2:0]  av;
            logic [31:0] last_d = '0;
            forever begin
                @(negedge clk);
                if (last_rst) begin
                    last_d = '0;
                    chk(g, "reset_ctrl", 64'({mem_en, mem_we, i_ack, d_ack, v_ack}), 64'd0);
                    chk(g, "reset_data", 64'(mem_addr | mem_wdata | i_rdata | d_rdata | v_rdata), 64'd0);
                end else begin
                    if (mem_en) begin
                        chk(g, "mem_en_expected", 64'(q_issue.size() > 0), 64'd1);
                        if (q_issue.size() > 0) begin
                            e = q_issue.pop_front();
                            chk(g, "issue_cycle", 64'(cyc), 64'(e.cyc));
                            chk(g, "issue_we_addr", {31'd0, mem_we, mem_addr}, {31'd0, e.we, e.addr});
                            if (e.we) chk(g, "issue_wdata", 64'(mem_wdata), 64'(e.wdata));
                        end
                    end
                    while (q_issue.size() > 0 && q_issue[0].cyc < cyc) begin
                        chk(g, "mem_en_missing", 64'(cyc), 64'(q_issue[0].cyc));
                        void'(q_issue.pop_front());
                    end
                    av = {v_ack, d_ack, i_ack};
                    if (av != 3'd0) begin
                        chk(g, "ack_expected", 64'(q_ack.size() > 0), 64'd1);
                        if (q_ack.size() > 0) begin
                            e = q_ack.pop_front();
                            chk(g, "ack_port", 64'(av), 64'(1) << e.port);
                            chk(g, "ack_cycle", 64'(cyc), 64'(e.cyc));
                            case (e.port)
                                2'd0: chk(g, "i_rdata", 64'(i_rdata), 64'(e.rdata));
                                2'd1: begin
                                    if (e.we) begin
                                        chk(g, "d_rdata_hold", 64'(d_rdata), 64'(last_d));
                                    end else begin
                                        chk(g, "d_rdata", 64'(d_rdata), 64'(e.rdata));
                                        last_d = e.rdata;
                                    end
                                end
                                default: chk(g, "v_rdata", 64'(v_rdata), 64'(e.rdata));
                            endcase
                        end
                    end
                    while (q_ack.size() > 0 && q_ack[0].cyc < cyc) begin
                        chk(g, "ack_missing", 64'(cyc), 64'(q_ack[0].cyc));
                        void'(q_ack.pop_front());
                    end
                end
            end
        end

        // Requesters: hold req until ack, then either re-request at once or idle a few cycles.
        initial begin : drv_i
            bit got;
            int gap;
            wait (cyc >= 4); #1;
            while (cyc < RUN) begin
                i_addr = rnd_addr(); i_req = 1'b1;
                got = 1'b0;
                for (int k = 0; k < TMO && !got; k++) begin @(posedge clk); #1; got = i_ack; end
                chk(g, "i_ack_timeout", 64'(got), 64'd1);
                gap = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
                if (gap > 0) begin i_req = 1'b0; repeat (gap) begin @(posedge clk); #1; end end
            end
            i_req = 1'b0;
        end

        initial begin : drv_d
            bit got;
            int gap;
            wait (cyc >= 4); #1;
            while (cyc < RUN) begin
                d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_req = 1'b1;
                got = 1'b0;
                for (int k = 0; k < TMO && !got; k++) begin @(posedge clk); #1; got = d_ack; end
                chk(g, "d_ack_timeout", 64'(got), 64'd1);
                gap = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
                if (gap > 0) begin d_req = 1'b0; repeat (gap) begin @(posedge clk); #1; end end
            end
            d_req = 1'b0;
        end

        initial begin : drv_v
            bit got;
            int gap;
            wait (cyc >= 4); #1;
            while (cyc < RUN) begin
                v_addr = rnd_addr(); v_req = 1'b1;
                got = 1'b0;
                for (int k = 0; k < TMO && !got; k++) begin @(posedge clk); #1; got = v_ack; end
                chk(g, "v_ack_timeout", 64'(got), 64'd1);
                gap = ($urandom_range(0, 2) != 0) ? 0 : int'($urandom_range(1, 6));
                if (gap > 0) begin v_req = 1'b0; repeat (gap) begin @(posedge clk); #1; end end
            end
            v_req = 1'b0;
        end

        // Reset: power-on, then pulses landing the cycle after a mem_en strobe.
        initial begin
            bit got;
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            for (int r = 0; r < 2; r++) begin
                wait (cyc >= 800 + r * 900);
                got = 1'b0;
                for (int k = 0; k < 200 && !got; k++) begin @(negedge clk); got = mem_en; end
                chk(g, "rst_mem_en_seen", 64'(got), 64'd1);
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end
        end

        initial begin
            wait (cyc >= RUN + 2 * TMO);
            chk(g, "drain_queues", 64'(q_issue.size() + q_ack.size()), 64'd0);
            done_cnt++;
        end
    end

    initial begin
        wait (done_cnt == 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
